// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and constants for the MAC accumulator stage
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

    localparam int MAC_PROD_W = 16;
    localparam int MAC_ACC_W  = 24;

endpackage

// File: rtl/acc_sat_adder.sv
// rtl/acc_sat_adder.sv - ripple-carry signed adder with clamp to the ACC_W range
module acc_sat_adder #(
    parameter int ACC_W = mac_pkg::MAC_ACC_W
) (
    input  logic [ACC_W-1:0] a_i,
    input  logic [ACC_W-1:0] b_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             ovf_o
);

    logic [ACC_W:0] a_x;
    logic [ACC_W:0] b_x;
    logic [ACC_W:0] raw;
    logic           carry;

    // One guard bit: the top two bits of raw disagree exactly when the sum left the range.
    always_comb begin
        a_x   = {a_i[ACC_W-1], a_i};
        b_x   = {b_i[ACC_W-1], b_i};
        raw   = '0;
        carry = 1'b0;
        for (int i = 0; i <= ACC_W; i++) begin
            raw[i] = a_x[i] ^ b_x[i] ^ carry;
            carry  = (a_x[i] & b_x[i]) | (carry & (a_x[i] ^ b_x[i]));
        end
    end

    always_comb begin
        sum_o = raw[ACC_W-1:0];
        ovf_o = 1'b0;
        if (raw[ACC_W] != raw[ACC_W-1]) begin
            ovf_o = 1'b1;
            sum_o = raw[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - accumulates a programmed number of MAC products into one saturating result
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int ACC_W  = MAC_ACC_W,
    parameter int LEN_W  = 8,
    parameter int PROD_W = MAC_PROD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] product,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              busy,
    output logic [LEN_W-1:0]  remaining,
    output logic              sat_flag,
    output logic              drop_err
);

    acc_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             sat_q, sat_d;
    logic             drop_q, drop_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] sum;
    logic             ovf;

    assign addend = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};

    acc_sat_adder #(
        .ACC_W(ACC_W)
    ) u_adder (
        .a_i  (acc_q),
        .b_i  (addend),
        .sum_o(sum),
        .ovf_o(ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        sat_d   = sat_q;
        drop_d  = drop_q;

        case (state_q)
            ACCUM: begin
                if (prod_valid) begin
                    acc_d = sum;
                    sat_d = sat_q | ovf;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (prod_valid) begin
                    drop_d = 1'b1;
                end
                if (acc_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (prod_valid) begin
                    drop_d = 1'b1;
                end
            end
        endcase

        // A start accepted from IDLE, or alongside the HOLD transfer, opens a fresh operation.
        if (start && (state_q == IDLE || (state_q == HOLD && acc_ready))) begin
            acc_d   = '0;
            sat_d   = 1'b0;
            drop_d  = 1'b0;
            rem_d   = vec_len;
            state_d = (vec_len == '0) ? HOLD : ACCUM;
        end

        valid_d = (state_d == HOLD);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            sat_q   <= 1'b0;
            drop_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            sat_q   <= sat_d;
            drop_q  <= drop_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign acc_out   = acc_q;
    assign acc_valid = valid_q;
    assign busy      = busy_q;
    assign remaining = rem_q;
    assign sat_flag  = sat_q;
    assign drop_err  = drop_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - directed table-driven bench for mac_accumulator (ACC_W 24 and 17)
module tb_mac_accumulator;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  vec_len;
    logic        prod_valid;
    logic [15:0] product;
    logic        acc_ready;

    logic [23:0] acc24;
    logic        v24, busy24, sat24, drop24;
    logic [7:0]  rem24;
    logic [16:0] acc17;
    logic        v17, busy17, sat17, drop17;
    logic [7:0]  rem17;

    int checks;
    int errors;

    mac_accumulator #(.ACC_W(24), .LEN_W(8), .PROD_W(16)) dut24 (
        .clk(clk), .rst(rst), .start(start), .vec_len(vec_len),
        .prod_valid(prod_valid), .product(product),
        .acc_out(acc24), .acc_valid(v24), .acc_ready(acc_ready),
        .busy(busy24), .remaining(rem24), .sat_flag(sat24), .drop_err(drop24)
    );

    mac_accumulator #(.ACC_W(17), .LEN_W(8), .PROD_W(16)) dut17 (
        .clk(clk), .rst(rst), .start(start), .vec_len(vec_len),
        .prod_valid(prod_valid), .product(product),
        .acc_out(acc17), .acc_valid(v17), .acc_ready(acc_ready),
        .busy(busy17), .remaining(rem17), .sat_flag(sat17), .drop_err(drop17)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [7:0]  len;
        logic        pv;
        logic [15:0] prod;
        logic        rdy;
        logic        d17;
        logic        e_valid;
        logic [23:0] e_acc;
        logic        e_busy;
        logic [7:0]  e_rem;
        logic        e_sat;
        logic        e_drop;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic st, input logic [7:0] len, input logic pv, input logic [15:0] prod,
                       input logic rdy, input logic d17, input logic e_valid, input logic [23:0] e_acc,
                       input logic e_busy, input logic [7:0] e_rem, input logic e_sat, input logic e_drop);
        vec_t v;
        v.st = st; v.len = len; v.pv = pv; v.prod = prod; v.rdy = rdy; v.d17 = d17;
        v.e_valid = e_valid; v.e_acc = e_acc; v.e_busy = e_busy; v.e_rem = e_rem;
        v.e_sat = e_sat; v.e_drop = e_drop;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_dut(input logic d17, input int idx, input logic e_valid, input logic [23:0] e_acc,
                           input logic e_busy, input logic [7:0] e_rem, input logic e_sat, input logic e_drop);
        if (d17) begin
            chk("acc_valid17", idx, {23'd0, v17}, {23'd0, e_valid});
            chk("acc_out17", idx, {7'd0, acc17}, e_acc);
            chk("busy17", idx, {23'd0, busy17}, {23'd0, e_busy});
            chk("remaining17", idx, {16'd0, rem17}, {16'd0, e_rem});
            chk("sat_flag17", idx, {23'd0, sat17}, {23'd0, e_sat});
            chk("drop_err17", idx, {23'd0, drop17}, {23'd0, e_drop});
        end else begin
            chk("acc_valid", idx, {23'd0, v24}, {23'd0, e_valid});
            chk("acc_out", idx, acc24, e_acc);
            chk("busy", idx, {23'd0, busy24}, {23'd0, e_busy});
            chk("remaining", idx, {16'd0, rem24}, {16'd0, e_rem});
            chk("sat_flag", idx, {23'd0, sat24}, {23'd0, e_sat});
            chk("drop_err", idx, {23'd0, drop24}, {23'd0, e_drop});
        end
    endtask

    task automatic drive(input logic st, input logic [7:0] len, input logic pv, input logic [15:0] prod,
                         input logic rdy);
        start = st; vec_len = len; prod_valid = pv; product = prod; acc_ready = rdy;
        @(posedge clk);
        #1;
        start = 1'b0; prod_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        start = 1'b0; vec_len = '0; prod_valid = 1'b0; product = '0; acc_ready = 1'b0;

        // Basic dot product, ignored start in ACCUM, drop in IDLE
        add(1, 3, 0, 16'h0000, 1, 0, 0, 24'h000000, 1, 3, 0, 0);
        add(0, 0, 1, 16'h0406, 1, 0, 0, 24'h000406, 1, 2, 0, 0);
        add(1, 9, 0, 16'h0000, 1, 0, 0, 24'h000406, 1, 2, 0, 0);
        add(0, 0, 1, 16'hF85F, 1, 0, 0, 24'hFFFC65, 1, 1, 0, 0);
        add(0, 0, 0, 16'h0000, 1, 0, 0, 24'hFFFC65, 1, 1, 0, 0);
        add(0, 0, 1, 16'hED00, 1, 0, 1, 24'hFFE965, 1, 0, 0, 0);
        add(0, 0, 0, 16'h0000, 1, 0, 0, 24'hFFE965, 0, 0, 0, 0);
        add(0, 0, 1, 16'h1234, 1, 0, 0, 24'hFFE965, 0, 0, 0, 1);
        // Zero length and back-pressure
        add(1, 0, 0, 16'h0000, 0, 0, 1, 24'h000000, 1, 0, 0, 0);
        add(0, 0, 0, 16'h0000, 0, 0, 1, 24'h000000, 1, 0, 0, 0);
        add(0, 0, 0, 16'h0000, 1, 0, 0, 24'h000000, 0, 0, 0, 0);
        add(1, 1, 0, 16'h0000, 0, 0, 0, 24'h000000, 1, 1, 0, 0);
        add(0, 0, 1, 16'h0100, 0, 0, 1, 24'h000100, 1, 0, 0, 0);
        add(0, 0, 0, 16'h0000, 0, 0, 1, 24'h000100, 1, 0, 0, 0);
        add(0, 0, 0, 16'h0000, 0, 0, 1, 24'h000100, 1, 0, 0, 0);
        add(0, 0, 1, 16'h7FFF, 0, 0, 1, 24'h000100, 1, 0, 0, 1);
        add(1, 3, 0, 16'h0000, 0, 0, 1, 24'h000100, 1, 0, 0, 1);
        add(0, 0, 0, 16'h0000, 0, 0, 1, 24'h000100, 1, 0, 0, 1);
        add(0, 0, 0, 16'h0000, 1, 0, 0, 24'h000100, 0, 0, 0, 1);
        // Back-to-back transfer plus start, including a zero-length restart
        add(1, 1, 0, 16'h0000, 0, 0, 0, 24'h000000, 1, 1, 0, 0);
        add(0, 0, 1, 16'h0003, 0, 0, 1, 24'h000003, 1, 0, 0, 0);
        add(1, 2, 0, 16'h0000, 1, 0, 0, 24'h000000, 1, 2, 0, 0);
        add(0, 0, 1, 16'h0005, 0, 0, 0, 24'h000005, 1, 1, 0, 0);
        add(0, 0, 1, 16'hFFF9, 0, 0, 1, 24'hFFFFFE, 1, 0, 0, 0);
        add(0, 0, 0, 16'h0000, 0, 0, 1, 24'hFFFFFE, 1, 0, 0, 0);
        add(1, 0, 0, 16'h0000, 1, 0, 1, 24'h000000, 1, 0, 0, 0);
        add(0, 0, 0, 16'h0000, 1, 0, 0, 24'h000000, 0, 0, 0, 0);
        // Saturation at ACC_W=17, positive then negative
        add(1, 4, 0, 16'h0000, 0, 1, 0, 24'h000000, 1, 4, 0, 0);
        add(0, 0, 1, 16'h4000, 0, 1, 0, 24'h004000, 1, 3, 0, 0);
        add(0, 0, 1, 16'h4000, 0, 1, 0, 24'h008000, 1, 2, 0, 0);
        add(0, 0, 1, 16'h4000, 0, 1, 0, 24'h00C000, 1, 1, 0, 0);
        add(0, 0, 1, 16'h4000, 0, 1, 1, 24'h00FFFF, 1, 0, 1, 0);
        add(0, 0, 0, 16'h0000, 1, 1, 0, 24'h00FFFF, 0, 0, 1, 0);
        add(1, 5, 0, 16'h0000, 0, 1, 0, 24'h000000, 1, 5, 0, 0);
        add(0, 0, 1, 16'hC000, 0, 1, 0, 24'h01C000, 1, 4, 0, 0);
        add(0, 0, 1, 16'hC000, 0, 1, 0, 24'h018000, 1, 3, 0, 0);
        add(0, 0, 1, 16'hC000, 0, 1, 0, 24'h014000, 1, 2, 0, 0);
        add(0, 0, 1, 16'hC000, 0, 1, 0, 24'h010000, 1, 1, 0, 0);
        add(0, 0, 1, 16'hFFFF, 0, 1, 1, 24'h010000, 1, 0, 1, 0);
        add(0, 0, 0, 16'h0000, 1, 1, 0, 24'h010000, 0, 0, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        chk_dut(0, -1, 0, 24'h0, 0, 0, 0, 0);
        chk_dut(1, -1, 0, 24'h0, 0, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].st, tbl[i].len, tbl[i].pv, tbl[i].prod, tbl[i].rdy);
            chk_dut(tbl[i].d17, i, tbl[i].e_valid, tbl[i].e_acc, tbl[i].e_busy,
                    tbl[i].e_rem, tbl[i].e_sat, tbl[i].e_drop);
        end

        // Reset between clock edges mid-ACCUM must clear everything at once
        drive(1, 4, 0, 16'h0000, 0);
        drive(0, 0, 1, 16'h0064, 0);
        drive(0, 0, 1, 16'h00C8, 0);
        chk_dut(0, 100, 0, 24'h00012C, 1, 2, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_dut(0, 101, 0, 24'h0, 0, 0, 0, 0);
        chk_dut(1, 101, 0, 24'h0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1, 1, 0, 16'h0000, 0);
        chk_dut(0, 102, 0, 24'h0, 1, 1, 0, 0);
        drive(0, 0, 1, 16'd42, 0);
        chk_dut(0, 103, 1, 24'd42, 1, 0, 0, 0);

        // Reset while in HOLD
        #2;
        rst = 1'b1;
        #1;
        chk_dut(0, 104, 0, 24'h0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 16'h0000, 1);
        chk_dut(0, 105, 0, 24'h0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
